// File: rtl/blob_compositor_if.sv
`default_nettype none
// ============================================================================
// blob_compositor_if : raw timing/pixel inputs and VGA pin outputs
// Rev 1.0
// ============================================================================
interface blob_compositor_if #(
    parameter int FRAME_W = 16
);
    logic                hsync_in;
    logic                vsync_in;
    logic                blank_in;
    logic [23:0]         fg_pixel;
    logic [23:0]         bg_pixel;
    logic                fg_en_req;
    logic                key_en_req;
    logic [23:0]         key_color_req;
    logic [7:0]          vga_r;
    logic [7:0]          vga_g;
    logic [7:0]          vga_b;
    logic                vga_hsync;
    logic                vga_vsync;
    logic                vga_blank;
    logic [FRAME_W-1:0]  frame_count;

    modport master (
        output hsync_in, vsync_in, blank_in, fg_pixel, bg_pixel,
               fg_en_req, key_en_req, key_color_req,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank, frame_count
    );

    modport slave (
        input  hsync_in, vsync_in, blank_in, fg_pixel, bg_pixel,
               fg_en_req, key_en_req, key_color_req,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/blob_compositor.sv
`default_nettype none
// ============================================================================
// blob_compositor : delays VGA timing to pixel latency, composites blob over
// background with colour-key transparency; controls shadowed per frame.
// Rev 1.0
// ============================================================================
module blob_compositor #(
    parameter int PIX_LAT = 3,
    parameter int FRAME_W = 16
) (
    input wire              pixel_clk,
    input wire              rst_n,
    blob_compositor_if.slave bus
);

    // {hsync, vsync, blank}; stage PIX_LAT-1 lines up with fg/bg pixels
    logic [PIX_LAT-1:0][2:0] dly_q, dly_d;

    logic               vs_prev_q, vs_prev_d;
    logic               fg_en_q, fg_en_d;
    logic               key_en_q, key_en_d;
    logic [23:0]        key_color_q, key_color_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;

    logic [23:0]        rgb_q, rgb_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               bl_q, bl_d;

    logic               hs_al, vs_al, bl_al;
    logic               frame_edge;
    logic               fg_visible;

    assign hs_al = dly_q[PIX_LAT-1][2];
    assign vs_al = dly_q[PIX_LAT-1][1];
    assign bl_al = dly_q[PIX_LAT-1][0];

    // Frame boundary is the raw vsync falling edge, not the delayed one
    assign frame_edge = vs_prev_q & ~bus.vsync_in;

    assign fg_visible = fg_en_q && (bus.fg_pixel != 24'd0) &&
                        !(key_en_q && (bus.fg_pixel == key_color_q));

    always_comb begin
        dly_d[0] = {bus.hsync_in, bus.vsync_in, bus.blank_in};
        for (int i = 1; i < PIX_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        vs_prev_d     = bus.vsync_in;
        fg_en_d       = fg_en_q;
        key_en_d      = key_en_q;
        key_color_d   = key_color_q;
        frame_count_d = frame_count_q;
        if (frame_edge) begin
            fg_en_d       = bus.fg_en_req;
            key_en_d      = bus.key_en_req;
            key_color_d   = bus.key_color_req;
            frame_count_d = frame_count_q + FRAME_W'(1);
        end

        hs_d = hs_al;
        vs_d = vs_al;
        bl_d = bl_al;
        if (bl_al) begin
            rgb_d = 24'd0;
        end else if (fg_visible) begin
            rgb_d = bus.fg_pixel;
        end else begin
            rgb_d = bus.bg_pixel;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q         <= '1;
            vs_prev_q     <= 1'b1;
            fg_en_q       <= 1'b0;
            key_en_q      <= 1'b0;
            key_color_q   <= 24'd0;
            frame_count_q <= '0;
            rgb_q         <= 24'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            bl_q          <= 1'b1;
        end else begin
            dly_q         <= dly_d;
            vs_prev_q     <= vs_prev_d;
            fg_en_q       <= fg_en_d;
            key_en_q      <= key_en_d;
            key_color_q   <= key_color_d;
            frame_count_q <= frame_count_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            bl_q          <= bl_d;
        end
    end

    assign bus.vga_r       = rgb_q[23:16];
    assign bus.vga_g       = rgb_q[15:8];
    assign bus.vga_b       = rgb_q[7:0];
    assign bus.vga_hsync   = hs_q;
    assign bus.vga_vsync   = vs_q;
    assign bus.vga_blank   = bl_q;
    assign bus.frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_blob_compositor.sv
`default_nettype none
// ============================================================================
// tb_blob_compositor : directed stimulus with a per-cycle scoreboard model
// Rev 1.0
// ============================================================================
module tb_blob_compositor;

    localparam int PIX_LAT = 3;
    localparam int FRAME_W = 4;

    logic pixel_clk = 1'b0;
    logic rst_n;

    always #5 pixel_clk = ~pixel_clk;

    blob_compositor_if #(.FRAME_W(FRAME_W)) bus ();

    blob_compositor #(
        .PIX_LAT (PIX_LAT),
        .FRAME_W (FRAME_W)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic [23:0]        rgb;
        logic               hs;
        logic               vs;
        logic               bl;
        logic [FRAME_W-1:0] fc;
    } obs_t;

    obs_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // stimulus values for the next cycle
    logic        hs = 1'b1, vs = 1'b1, bl = 1'b1;
    logic [23:0] fg = 24'd0, bg = 24'd0;
    logic        fe = 1'b0, ke = 1'b0;
    logic [23:0] kc = 24'd0;

    // reference model state
    logic [2:0]         m_hist [PIX_LAT];
    logic               m_prev, m_fe, m_ke;
    logic [23:0]        m_kc;
    logic [FRAME_W-1:0] m_fc;

    function automatic obs_t sample();
        return {bus.vga_r, bus.vga_g, bus.vga_b,
                bus.vga_hsync, bus.vga_vsync, bus.vga_blank, bus.frame_count};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PIX_LAT; i++) m_hist[i] = 3'b111;
        m_prev = 1'b1;
        m_fe   = 1'b0;
        m_ke   = 1'b0;
        m_kc   = 24'd0;
        m_fc   = '0;
    endtask

    task automatic drive();
        bus.hsync_in      = hs;
        bus.vsync_in      = vs;
        bus.blank_in      = bl;
        bus.fg_pixel      = fg;
        bus.bg_pixel      = bg;
        bus.fg_en_req     = fe;
        bus.key_en_req    = ke;
        bus.key_color_req = kc;
    endtask

    // Drive one cycle, predict the pins after the next edge, then compare.
    task automatic tick(input string tag);
        obs_t       e, o;
        logic       fe_edge;
        logic [2:0] old;
        drive();
        old     = m_hist[PIX_LAT-1];
        fe_edge = m_prev & ~vs;
        e.hs = old[2];
        e.vs = old[1];
        e.bl = old[0];
        if (old[0])                                          e.rgb = 24'd0;
        else if (m_fe && fg != 24'd0 && !(m_ke && fg == m_kc)) e.rgb = fg;
        else                                                 e.rgb = bg;
        e.fc = fe_edge ? m_fc + FRAME_W'(1) : m_fc;
        sb_q.push_back(e);
        for (int i = PIX_LAT-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = {hs, vs, bl};
        m_prev    = vs;
        if (fe_edge) begin
            m_fe = fe;
            m_ke = ke;
            m_kc = kc;
            m_fc = e.fc;
        end
        @(posedge pixel_clk);
        #1;
        o = sample();
        e = sb_q.pop_front();
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive();
        model_reset();
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_rgb",  {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h0);
        chk("rst_sync", {bus.vga_hsync, bus.vga_vsync, bus.vga_blank}, 32'h7);
        chk("rst_fc",   bus.frame_count, 32'h0);
        rst_n = 1'b1;

        // latency of sync and pixel paths
        bl = 1'b0;
        bg = 24'h000001;
        repeat (6) tick("idle");
        hs = 1'b0;
        tick("hs_pulse");
        hs = 1'b1;
        tick("hs_prop");
        tick("hs_prop");
        chk("hs_early", bus.vga_hsync, 32'h1);
        tick("hs_prop");
        chk("hs_lat", bus.vga_hsync, 32'h0);
        tick("hs_prop");
        chk("hs_end", bus.vga_hsync, 32'h1);
        bg = 24'h123456;
        tick("bg_pix");
        chk("bg_lat1", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h123456);

        // colour keying enabled at frame 1
        fe = 1'b1; ke = 1'b1; kc = 24'hFF00FF;
        vs = 1'b0;
        tick("vs_fall1");
        tick("vs_low1");
        vs = 1'b1;
        tick("vs_high1");
        chk("frame1", bus.frame_count, 32'h1);
        fg = 24'hFF00FF; bg = 24'h000080;
        tick("key_match");
        chk("key_match", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h000080);
        fg = 24'h00FF00;
        tick("key_pass");
        chk("key_pass", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h00FF00);
        fg = 24'h0;
        tick("fg_zero");
        chk("fg_zero", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h000080);

        // blanking overrides both layers
        bl = 1'b1; fg = 24'hFFFFFF; bg = 24'hFFFFFF;
        repeat (3) tick("blank_fill");
        tick("blank");
        chk("blank_rgb",  {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h0);
        chk("blank_flag", bus.vga_blank, 32'h1);

        // shadowing: foreground disabled at frame 2, re-requested mid-frame
        fe = 1'b0;
        vs = 1'b0;
        tick("vs_fall2");
        vs = 1'b1;
        tick("vs_high2");
        bl = 1'b0;
        repeat (4) tick("unblank");
        fe = 1'b1; fg = 24'h00FF00; bg = 24'h000011;
        tick("shadow_hold");
        chk("shadow_hold", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h000011);
        repeat (3) tick("mid_frame");
        vs = 1'b0;
        tick("vs_fall3");
        chk("edge_still_bg", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h000011);
        tick("vs_low3");
        chk("fg_after_edge", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h00FF00);
        repeat (18) tick("vs_hold");
        chk("vs_hold_once", bus.frame_count, 32'h3);
        vs = 1'b1;
        repeat (4) tick("vs_high3");
        chk("pre_reset_fg", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h00FF00);

        // asynchronous reset in active video
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rgb",  {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h0);
        chk("async_sync", {bus.vga_hsync, bus.vga_vsync, bus.vga_blank}, 32'h7);
        chk("async_fc",   bus.frame_count, 32'h0);
        @(posedge pixel_clk);
        @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick("post_rst");
        chk("rel_blank", bus.vga_blank, 32'h1);
        tick("post_rst");
        chk("rel_unblank", bus.vga_blank, 32'h0);
        chk("rel_fg_off", {bus.vga_r, bus.vga_g, bus.vga_b}, 32'h000011);
        chk("rel_fc", bus.frame_count, 32'h0);

        // frame counter wraps after 16 frames
        for (int k = 1; k <= 16; k++) begin
            vs = 1'b0;
            tick("wrap_low");
            vs = 1'b1;
            tick("wrap_high");
            if (k == 15) chk("wrap_15", bus.frame_count, 32'hF);
            if (k == 16) chk("wrap_0",  bus.frame_count, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blob_compositor.md
Name: blob_compositor

Overview:
- Stage directly downstream of the picture-blob pixel generator and upstream of the VGA DAC pins.
- Delays the raw timing signals (hsync, vsync, blank) to match the blob's pixel latency.
- Selects between blob (foreground) and background pixel, with colour-key transparency.
- Control inputs apply only at frame boundaries (shadowed), so layers never tear mid-frame.

Parameters:
PIX_LAT, 3, cycles from hcount/vcount valid to fg_pixel/bg_pixel valid; legal range 1..8
FRAME_W, 16, width of frame_count

Ports:
pixel_clk  in  1  pixel clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
hsync_in  in  1  active-low hsync, aligned with hcount/vcount
vsync_in  in  1  active-low vsync, aligned with hcount/vcount
blank_in  in  1  active-high blank, aligned with hcount/vcount
fg_pixel  in  24  blob pixel {R,G,B}; 0 outside blob window; valid PIX_LAT cycles after the matching hcount
bg_pixel  in  24  background pixel, same alignment as fg_pixel
fg_en_req  in  1  requested foreground enable
key_en_req  in  1  requested colour-key enable
key_color_req  in  24  requested transparent colour
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hsync  out  1  delayed hsync
vga_vsync  out  1  delayed vsync
vga_blank  out  1  delayed blank
frame_count  out  FRAME_W  frames since reset

Behaviour:
- Reset (async assert, sync-released by the system):
  - vga_r/g/b = 0; vga_hsync = 1; vga_vsync = 1; vga_blank = 1; frame_count = 0.
  - Every delay-line stage holds hsync = 1, vsync = 1, blank = 1.
  - Active (shadow) registers: fg_en = 0, key_en = 0, key_color = 0.
  - Previous-vsync register = 1.
- Delay line:
  - PIX_LAT-deep shift register of {hsync, vsync, blank}.
  - Stage-PIX_LAT outputs (hs_d, vs_d, bl_d) are aligned with fg_pixel/bg_pixel.
- Output stage: one register stage for all outputs.
  - Sync and blank latency, input to pin = PIX_LAT + 1 cycles.
  - Pixel latency, fg/bg input to pin = 1 cycle.
- Composition, evaluated each cycle on the aligned signals:
  - bl_d = 1: RGB = 0.
  - Otherwise, if fg_en_act = 1, fg_pixel != 0, and NOT (key_en_act = 1 AND fg_pixel == key_color_act): RGB = fg_pixel.
  - Otherwise: RGB = bg_pixel.
  - fg_pixel == 0 is always transparent, whatever the key settings.
- Frame boundary:
  - Defined as a falling edge of raw vsync_in: prev = 1, vsync_in = 0, sampled on the same clock.
  - On the clock edge that detects it, active registers load fg_en_req, key_en_req, key_color_req.
  - frame_count increments on that same edge; it wraps from all-ones to 0 with no flag.
  - Req inputs are ignored on all other cycles; changing them mid-frame has no visible effect.
  - vsync_in held low does not retrigger; only the 1->0 transition counts.
- Reset mid-frame: all state returns to reset values immediately.
  - Outputs stay blanked, with syncs inactive, until real timing has propagated PIX_LAT + 1 cycles after release.
  - The foreground stays disabled until the next vsync falling edge.
- No back-pressure and no handshake: one pixel per clock, every clock.

Test Plan:
- Latency: PIX_LAT = 3; pulse hsync_in low for 1 cycle at t0 -> vga_hsync low only at t0+4; bg_pixel = 24'h123456 at t1 with blank low -> vga RGB = 12/34/56 at t1+1.
- Keying:
  - Frame 1: reqs fg_en = 1, key_en = 1, key = 24'hFF00FF; then vsync falls.
  - fg = FF00FF, bg = 000080 -> output 000080.
  - fg = 00FF00 -> output 00FF00.
  - fg = 0 -> bg.
- Blank: bl_d = 1 with fg = FFFFFF, bg = FFFFFF -> RGB = 0, and vga_blank = 1 in the same cycle.
- Shadowing:
  - Raise fg_en_req mid-frame -> output remains bg until the clock after the vsync_in falling edge.
  - Then fg is shown.
  - Holding vsync low 2 lines increments frame_count by exactly 1.
- Reset mid-frame:
  - Assert rst_n = 0 asynchronously during active video -> outputs 0/1/1/1 without waiting for a clock edge.
  - frame_count = 0 and fg disabled after release.
- Wrap: FRAME_W = 4; drive 16 vsync falling edges -> frame_count goes 15 -> 0.
